// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative mult/multu/div/divu (one bit per cycle) with architectural HI/LO registers.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_l,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
    state_t state, next;
    logic [CW-1:0] cnt;
    logic [1:0] op_q;
    logic [WIDTH:0] acc_hi, term, sum, shl, trial, nhi;
    logic [WIDTH-1:0] acc_lo, m_q, nlo, a_mag, b_mag, res_hi, res_lo;
    logic qm1, neg_q, neg_r, dz_q, accept, dz_start, last, sgn, ok;
    assign accept   = start && state != CALC;
    assign dz_start = accept && op[1] && b == '0;
    assign last     = state == CALC && cnt == CW'(WIDTH - 1);
    assign busy     = state == CALC;
    assign done     = state == FINISH;
    assign div_zero = done && dz_q;
    assign a_mag    = (op == 2'b10 && a[WIDTH-1]) ? -a : a;
    assign b_mag    = (op == 2'b10 && b[WIDTH-1]) ? -b : b;
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) state <= IDLE;
        else          state <= next;
    end
    always_comb begin
        next = accept ? (dz_start ? FINISH : CALC) : (state == CALC ? (last ? FINISH : CALC) : IDLE);
    end
    // Multiply: Booth (signed) or plain shift-add on a WIDTH+1 upper half so the add never overflows.
    // Divide: restoring step on magnitudes; signs are reapplied to the final step's outputs.
    always_comb begin
        sgn    = !op_q[0];
        term   = sgn ? ((acc_lo[0] && !qm1) ? -{m_q[WIDTH-1], m_q} :
                        (!acc_lo[0] && qm1) ? {m_q[WIDTH-1], m_q} : '0)
                     : (acc_lo[0] ? {1'b0, m_q} : '0);
        sum    = acc_hi + term;
        shl    = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        trial  = shl - {1'b0, m_q};
        ok     = !trial[WIDTH];
        nhi    = op_q[1] ? (ok ? trial : shl) : {sgn & sum[WIDTH], sum[WIDTH:1]};
        nlo    = op_q[1] ? {acc_lo[WIDTH-2:0], ok} : {sum[0], acc_lo[WIDTH-1:1]};
        res_lo = (op_q[1] && neg_q) ? -nlo : nlo;
        res_hi = (op_q[1] && neg_r) ? -nhi[WIDTH-1:0] : nhi[WIDTH-1:0];
    end
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            cnt    <= '0;
            op_q   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            m_q    <= '0;
            qm1    <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz_q   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (accept) begin
                cnt    <= '0;
                op_q   <= op;
                acc_hi <= '0;
                acc_lo <= op[1] ? a_mag : b;
                m_q    <= op[1] ? b_mag : a;
                qm1    <= 1'b0;
                neg_q  <= op == 2'b10 && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= op == 2'b10 && a[WIDTH-1];
                dz_q   <= dz_start;
            end else if (busy) begin
                cnt    <= cnt + 1'b1;
                acc_hi <= nhi;
                acc_lo <= nlo;
                qm1    <= acc_lo[0];
            end
            if (last) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (!busy) begin
                if (wr_hi) hi <= wr_data;
                if (wr_lo) lo <= wr_data;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit at WIDTH=32, plus a WIDTH=8 instance.
module tb_mult_div_unit;
    localparam int W = 32;
    logic clock = 0, reset_l = 0, start = 0, wr_hi = 0, wr_lo = 0, start8 = 0;
    logic [1:0] op = 0, op8 = 0;
    logic [W-1:0] a = 0, b = 0, wr_data = 0, hi, lo;
    logic [7:0] a8 = 0, b8 = 0, hi8, lo8;
    logic busy, done, div_zero, busy8, done8, dz8;
    int total = 0, bad = 0;
    logic [W-1:0] mhi = 0, mlo = 0;
    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;
    exp_t sb[$];

    mult_div_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset_l(reset_l), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo));

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_l(reset_l), .start(start8), .op(op8), .a(a8), .b(b8),
        .wr_hi(1'b0), .wr_lo(1'b0), .wr_data(8'h00), .busy(busy8), .done(done8),
        .div_zero(dz8), .hi(hi8), .lo(lo8));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {hi, lo} for a w-bit operation, built with 64-bit integer arithmetic.
    function automatic logic [63:0] model(input int w, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint msk, ux, uy, sx, sy, p, q, r;
        msk = (longint'(1) << w) - 1;
        ux = longint'(x) & msk;
        uy = longint'(y) & msk;
        sx = (ux << (64 - w)) >>> (64 - w);
        sy = (uy << (64 - w)) >>> (64 - w);
        if (!o[1]) begin
            p = o[0] ? ux * uy : sx * sy;
            return {32'((p >> w) & msk), 32'(p & msk)};
        end
        q = o[0] ? ux / uy : sx / sy;
        r = o[0] ? ux % uy : sx % sy;
        return {32'(r & msk), 32'(q & msk)};
    endfunction

    task automatic push_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        if (o[1] && y == 0) begin
            e.hi = mhi;
            e.lo = mlo;
            e.dz = 1'b1;
        end else begin
            {e.hi, e.lo} = model(W, o, x, y);
            e.dz = 1'b0;
        end
        sb.push_back(e);
        mhi = e.hi;
        mlo = e.lo;
    endtask

    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clock);
        start = 1; op = o; a = x; b = y;
        push_op(o, x, y);
        @(posedge clock);
        #1 start = 0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc = 0;
        while (!done && lat < 100) begin
            if (busy) bc++;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int exp_lat);
        int lat, bc;
        launch(o, x, y);
        wait_done(lat, bc);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, bc, exp_lat);
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int lat;
        logic [63:0] e;
        @(negedge clock);
        start8 = 1; op8 = o; a8 = x; b8 = y;
        e = model(8, o, x, y);
        @(posedge clock);
        #1 start8 = 0;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("w8_latency", lat, 8);
        check("w8_hi", hi8, e[39:32]);
        check("w8_lo", lo8, e[7:0]);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset_l && done) begin
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("sb_hi", hi, e.hi);
                check("sb_lo", lo, e.lo);
                check("sb_div_zero", div_zero, e.dz);
            end
        end else if (div_zero) check("div_zero_without_done", div_zero, 0);
    end

    initial begin
        int lat, bc, dn;
        logic [1:0] o;
        logic [W-1:0] x, y;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge clock) reset_l = 1;
        run("smul", 2'b00, 32'd7, 32'hFFFF_FFFD, 32);
        check("smul_hi", hi, 32'hFFFF_FFFF);
        check("smul_lo", lo, 32'hFFFF_FFEB);
        @(posedge clock);
        #1 check("done_one_cycle", done, 0);
        run("umul", 2'b01, 32'hFFFF_FFFF, 32'd2, 32);
        check("umul_hi", hi, 32'h1);
        check("umul_lo", lo, 32'hFFFF_FFFE);
        run("sdiv", 2'b10, 32'hFFFF_FFF9, 32'd2, 32);
        check("sdiv_hi", hi, 32'hFFFF_FFFF);
        check("sdiv_lo", lo, 32'hFFFF_FFFD);
        run("ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32);
        check("ovf_hi", hi, 32'h0);
        check("ovf_lo", lo, 32'h8000_0000);
        @(negedge clock);
        wr_lo = 1; wr_data = 32'hABC;
        @(posedge clock);
        #1 wr_lo = 0;
        mlo = 32'hABC;
        check("finish_mtlo", lo, 32'hABC);
        @(negedge clock);
        wr_hi = 1; wr_data = 32'h1234;
        @(negedge clock);
        wr_hi = 0; wr_lo = 1; wr_data = 32'h5678;
        @(negedge clock);
        wr_lo = 0;
        mhi = 32'h1234;
        mlo = 32'h5678;
        check("mthi", hi, 32'h1234);
        check("mtlo", lo, 32'h5678);
        run("divzero", 2'b11, 32'd7, 32'd0, 0);
        check("dz_flag", div_zero, 1);
        check("dz_hi", hi, 32'h1234);
        check("dz_lo", lo, 32'h5678);
        launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(posedge clock);
        @(negedge clock);
        start = 1; op = 2'b00; a = 32'd1; b = 32'd1; wr_hi = 1; wr_data = 32'hDEAD_BEEF;
        @(posedge clock);
        #1 start = 0;
        wr_hi = 0;
        check("calc_mthi_ignored", hi, 32'h1234);
        wait_done(lat, bc);
        check("intf_done", done, 1);
        launch(2'b00, 32'hCAFE_F00D, 32'h0BAD_1DEA);
        repeat (10) @(posedge clock);
        #2 reset_l = 0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        sb.delete();
        mhi = 0;
        mlo = 0;
        @(negedge clock) reset_l = 1;
        dn = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if (y == 0) y = 1;
            run("rnd", o, x, y, 32);
        end
        run8(2'b00, 8'd7, 8'hFD);
        check("w8_smul_hi", hi8, 8'hFF);
        check("w8_smul_lo", lo8, 8'hEB);
        run8(2'b10, 8'h80, 8'hFF);
        run8(2'b01, 8'hFF, 8'hFF);
        run8(2'b10, 8'h9C, 8'h07);
        run8(2'b00, 8'h80, 8'h80);
        repeat (3) @(negedge clock);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
